// File: rtl/bm_lpm_split_pkg.sv
// Shared types and defaults for the tagged-word segment splitter.
package bm_lpm_split_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam int          BITS_DEF  = 32;
  localparam int          SEG_W_DEF = 8;
  localparam logic [7:0]  TAG_DEF   = 8'h56;
  localparam int          ERR_W_DEF = 8;

  function automatic int nseg(input int bits, input int seg_w);
    return bits / seg_w;
  endfunction

endpackage

// File: rtl/bm_lpm_split_tagchk.sv
// Leading-segment tag checker: one-cycle mismatch pulse plus saturating error counter.
module bm_lpm_split_tagchk
  import bm_lpm_split_pkg::*;
#(
  parameter int               SEG_W = SEG_W_DEF,
  parameter logic [SEG_W-1:0] TAG   = TAG_DEF,
  parameter int               ERR_W = ERR_W_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             check_i,
  input  logic [SEG_W-1:0] seg_i,
  output logic             tag_err_o,
  output logic [ERR_W-1:0] err_cnt_o
);

  logic             tag_err_q, tag_err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             mismatch;

  assign mismatch = check_i && (seg_i != TAG);

  // The counter sticks at all-ones, but the pulse still fires for every bad word.
  always_comb begin
    tag_err_d = mismatch;
    err_cnt_d = err_cnt_q;
    if (mismatch && (err_cnt_q != {ERR_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tag_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      tag_err_q <= tag_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign tag_err_o = tag_err_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: rtl/bm_lpm_split_stream.sv
// Splits each accepted tagged word into MSB-first segments on a valid/ready stream.
// Define BM_LPM_SPLIT_PARITY_EN to append an XOR parity segment after the data segments.
module bm_lpm_split_stream
  import bm_lpm_split_pkg::*;
#(
  parameter int               BITS  = BITS_DEF,
  parameter int               SEG_W = SEG_W_DEF,
  parameter logic [SEG_W-1:0] TAG   = TAG_DEF,
  parameter int               ERR_W = ERR_W_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [BITS-1:0]  in_word,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [SEG_W-1:0] out_seg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             tag_err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int NSEG  = nseg(BITS, SEG_W);
  localparam int IDX_W = $clog2(NSEG + 1);
`ifdef BM_LPM_SPLIT_PARITY_EN
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSEG);
`else
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSEG - 1);
`endif

  state_e            state_q, state_d;
  logic [BITS-1:0]   shreg_q, shreg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  idx_inc;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [SEG_W-1:0]  data_seg;
  logic              in_xfer;
  logic              out_xfer;
`ifdef BM_LPM_SPLIT_PARITY_EN
  logic [SEG_W-1:0]  par_q, par_d;
`endif

  assign data_seg = shreg_q[BITS-1 -: SEG_W];
  assign idx_inc  = idx_q + 1'b1;

  // A new word may enter while idle, or in the same cycle the final segment leaves.
  assign in_ready = (state_q == IDLE) || ((state_q == SEND) && out_last_q && out_ready);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
`ifdef BM_LPM_SPLIT_PARITY_EN
    par_d       = par_q;
`endif

    if (out_xfer) begin
      shreg_d    = shreg_q << SEG_W;
      idx_d      = idx_inc;
      out_last_d = (idx_inc == LAST_IDX);
`ifdef BM_LPM_SPLIT_PARITY_EN
      par_d      = par_q ^ data_seg;
`endif
      if (out_last_q) begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    end

    // Loading wins over the end-of-word return to IDLE, giving bubble-free streaming.
    if (in_xfer) begin
      state_d     = SEND;
      shreg_d     = in_word;
      idx_d       = '0;
      out_valid_d = 1'b1;
      out_last_d  = (LAST_IDX == '0);
`ifdef BM_LPM_SPLIT_PARITY_EN
      par_d       = '0;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
`ifdef BM_LPM_SPLIT_PARITY_EN
      par_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
`ifdef BM_LPM_SPLIT_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

`ifdef BM_LPM_SPLIT_PARITY_EN
  assign out_seg = (idx_q == IDX_W'(NSEG)) ? par_q : data_seg;
`else
  assign out_seg = data_seg;
`endif

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

  bm_lpm_split_tagchk #(
    .SEG_W (SEG_W),
    .TAG   (TAG),
    .ERR_W (ERR_W)
  ) u_tagchk (
    .clock     (clock),
    .reset_n   (reset_n),
    .check_i   (in_xfer),
    .seg_i     (in_word[BITS-1 -: SEG_W]),
    .tag_err_o (tag_err),
    .err_cnt_o (err_cnt)
  );

endmodule

// File: tb/tb_bm_lpm_split_stream.sv
// Self-checking bench for bm_lpm_split_stream: queue-based segment model plus directed literal checks.
module tb_bm_lpm_split_stream;

`ifdef BM_LPM_SPLIT_PARITY_EN
  localparam int NOUT = 5;
`else
  localparam int NOUT = 4;
`endif
  localparam logic [7:0] TAG = 8'h56;

  logic        clock;
  logic        reset_n;
  logic [31:0] in_word;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_seg;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        tag_err;
  logic [7:0]  err_cnt;

  int checkCount = 0;
  int passCount  = 0;
  int cyc        = 0;
  int acceptCyc  = 0;

  logic [8:0]  expQ[$];
  logic        tagErrExp = 1'b0;
  logic [7:0]  errCntExp = 8'h00;

  logic        capIn, capOut, capLast;
  logic [31:0] capWord;
  logic [7:0]  capSeg;

  logic [7:0]  logSeg[$];
  logic        logLast[$];
  int          logCyc[$];

  bm_lpm_split_stream dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_word   (in_word),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_seg   (out_seg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .tag_err   (tag_err),
    .err_cnt   (err_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    else passCount++;
  endtask

  // Expected output stream of one word: its segments MSB first, then optional XOR parity.
  function automatic void pushWord(input logic [31:0] w);
    logic [7:0] p;
    logic [7:0] s;
    p = 8'h00;
    for (int i = 0; i < 4; i++) begin
      s = w[31 - 8*i -: 8];
      p = p ^ s;
      expQ.push_back({(i == NOUT - 1), s});
    end
    if (NOUT == 5) expQ.push_back({1'b1, p});
  endfunction

  // Compare every cycle against the model, then capture the handshakes for the coming edge.
  always @(negedge clock) begin
    if (!reset_n) begin
      expQ.delete();
      tagErrExp = 1'b0;
      errCntExp = 8'h00;
    end
    checkOutput("out_valid", out_valid, expQ.size() != 0);
    checkOutput("in_ready", in_ready, (expQ.size() == 0) || (expQ.size() == 1 && out_ready));
    if (expQ.size() != 0) begin
      checkOutput("out_seg", out_seg, expQ[0][7:0]);
      checkOutput("out_last", out_last, expQ[0][8]);
    end
    checkOutput("tag_err", tag_err, tagErrExp);
    checkOutput("err_cnt", err_cnt, errCntExp);
    capIn   = reset_n && in_valid && in_ready;
    capOut  = reset_n && out_valid && out_ready;
    capWord = in_word;
    capSeg  = out_seg;
    capLast = out_last;
  end

  always @(posedge clock) begin
    cyc++;
    if (reset_n) begin
      tagErrExp = capIn && (capWord[31:24] != TAG);
      if (tagErrExp && errCntExp != 8'hFF) errCntExp = errCntExp + 8'd1;
      if (capOut) begin
        logSeg.push_back(capSeg);
        logLast.push_back(capLast);
        logCyc.push_back(cyc);
        if (expQ.size() != 0) void'(expQ.pop_front());
      end
      if (capIn) begin
        acceptCyc = cyc;
        pushWord(capWord);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the word is accepted.
  task automatic applyStimulus(input logic [31:0] w);
    int n;
    n = 0;
    in_word  = w;
    in_valid = 1'b1;
    @(negedge clock);
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      checkCount++;
      $display("[TB] FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    @(negedge clock);
    while (out_valid && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (out_valid) begin
      checkCount++;
      $display("[TB] FAIL drain_timeout: out_valid stayed %b, required 0", out_valid);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic clearLog();
    logSeg.delete();
    logLast.delete();
    logCyc.delete();
  endtask

  task automatic checkLog(input string name, input logic [7:0] exp[$]);
    checkOutput({name, "_count"}, logSeg.size(), exp.size());
    for (int i = 0; i < exp.size() && i < logSeg.size(); i++) begin
      checkOutput({name, "_seg"}, logSeg[i], exp[i]);
      checkOutput({name, "_last"}, logLast[i], (i == exp.size() - 1));
    end
  endtask

  initial begin
    logic [7:0] expSegs[$];
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_word   = 32'h0;
    out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_seg", out_seg, 8'h00);
    checkOutput("rst_err_cnt", err_cnt, 8'h00);
    @(posedge clock);
    #1;

    // Basic word, one-cycle latency to the first segment.
    clearLog();
    applyStimulus(32'h56ABCDEF);
    waitIdle();
    expSegs = '{8'h56, 8'hAB, 8'hCD, 8'hEF};
    if (NOUT == 5) expSegs.push_back(8'hDF);
    checkLog("basic", expSegs);
    if (logCyc.size() != 0) checkOutput("basic_latency", logCyc[0] - acceptCyc, 1);
    checkOutput("basic_err_cnt", err_cnt, 8'h00);

    // Stall on CD for three cycles.
    clearLog();
    applyStimulus(32'h56ABCDEF);
    @(posedge clock); #1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clock);
      checkOutput("stall_seg", out_seg, 8'hCD);
      checkOutput("stall_valid", out_valid, 1);
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    waitIdle();
    checkLog("stall", expSegs);

    // Back-to-back words, no bubble.
    clearLog();
    applyStimulus(32'h56000001);
    applyStimulus(32'h56FFFFFE);
    waitIdle();
    checkOutput("b2b_count", logSeg.size(), 2 * NOUT);
    for (int i = 0; i < logCyc.size(); i++) checkOutput("b2b_cycle", logCyc[i] - logCyc[0], i);
    if (logSeg.size() == 2 * NOUT) begin
      checkOutput("b2b_w0_last", logSeg[3], 8'h01);
      checkOutput("b2b_w1_first", logSeg[NOUT], 8'h56);
      checkOutput("b2b_w1_end", logSeg[NOUT + 3], 8'hFE);
    end

    // Tag mismatch: pulse, count, then saturation.
    clearLog();
    applyStimulus(32'h00112233);
    @(negedge clock);
    checkOutput("err_pulse", tag_err, 1);
    checkOutput("err_cnt_one", err_cnt, 8'h01);
    @(negedge clock);
    checkOutput("err_pulse_end", tag_err, 0);
    @(posedge clock); #1;
    waitIdle();
    expSegs = '{8'h00, 8'h11, 8'h22, 8'h33};
    if (NOUT == 5) expSegs.push_back(8'h00);
    checkLog("err_word", expSegs);
    for (int i = 0; i < 255; i++) applyStimulus(32'h00112233);
    waitIdle();
    checkOutput("err_cnt_sat", err_cnt, 8'hFF);
    applyStimulus(32'h00112233);
    @(negedge clock);
    checkOutput("err_sat_pulse", tag_err, 1);
    checkOutput("err_cnt_hold", err_cnt, 8'hFF);
    @(posedge clock); #1;
    waitIdle();

    // Reset after segment AB has transferred.
    clearLog();
    applyStimulus(32'h56ABCDEF);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    checkOutput("rst_mid_valid", out_valid, 0);
    checkOutput("rst_mid_err_cnt", err_cnt, 8'h00);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    checkOutput("rst_mid_in_ready", in_ready, 1);
    checkOutput("rst_mid_idle", out_valid, 0);
    checkOutput("rst_mid_log_count", logSeg.size(), 2);
    for (int i = 0; i < logLast.size(); i++) checkOutput("rst_mid_no_last", logLast[i], 0);
    @(posedge clock); #1;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
